// File: rtl/branch_target_buffer_if.sv
// ============================================================================
// Module   : branch_target_buffer_if
// Brief    : Lookup, update and flush bundle between fetch/execute and the BTB.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface branch_target_buffer_if #(
  parameter int INDEX_BITS = 3,
  parameter int WAYS       = 2
);
  localparam int CNT_W = $clog2(WAYS * (2 ** INDEX_BITS)) + 1;

  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             hit_valid;
  logic             hit;
  logic [31:0]      predicted_target;
  logic             valid_tag_and_target;
  logic [63:0]      tag_and_target_address;
  logic             flush_btb;
  logic [CNT_W-1:0] entry_count;

  modport master (
    output lookup_valid, lookup_pc, valid_tag_and_target,
           tag_and_target_address, flush_btb,
    input  hit_valid, hit, predicted_target, entry_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, valid_tag_and_target,
           tag_and_target_address, flush_btb,
    output hit_valid, hit, predicted_target, entry_count
  );
endinterface

`default_nettype wire

// File: rtl/branch_target_buffer.sv
// ============================================================================
// Module   : branch_target_buffer
// Brief    : 1/2-way set-associative BTB, one-cycle lookup, LRU replacement.
//            Optional macro BTB_BYPASS_EN forwards a same-cycle update to a
//            lookup of the identical PC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_target_buffer #(
  parameter int INDEX_BITS = 3,
  parameter int WAYS       = 2
) (
  input  wire                   clk,
  input  wire                   reset,
  branch_target_buffer_if.slave btb
);
  localparam int SETS  = 2 ** INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS;
  localparam int WAY_W = 1;
  localparam int CNT_W = $clog2(WAYS * SETS) + 1;

  generate
    if (WAYS != 1 && WAYS != 2) begin : g_ways_check
      $error("branch_target_buffer: WAYS must be 1 or 2");
    end
  endgenerate

  logic [WAYS-1:0]  r_valid  [SETS];
  logic [TAG_W-1:0] r_tag    [SETS][WAYS];
  logic [31:0]      r_target [SETS][WAYS];
  logic [SETS-1:0]  r_lru;
  logic [CNT_W-1:0] r_count;
  logic             r_hit_valid;
  logic             r_hit;
  logic [31:0]      r_pred;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic                  w_lk_hit;
  logic [WAY_W-1:0]      w_lk_way;
  logic [31:0]           w_lk_target;

  logic [31:0]           w_up_pc;
  logic [31:0]           w_up_tgt;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_W-1:0]      w_up_tag;
  logic                  w_up_match;
  logic [WAY_W-1:0]      w_up_match_way;
  logic                  w_up_free;
  logic [WAY_W-1:0]      w_up_free_way;
  logic [WAY_W-1:0]      w_victim;
  logic [WAY_W-1:0]      w_up_way;
  logic                  w_up_alloc;
  logic                  w_up_en;
  logic                  w_fwd;

  assign w_lk_idx = btb.lookup_pc[INDEX_BITS-1:0];
  assign w_lk_tag = btb.lookup_pc[31:INDEX_BITS];
  assign w_up_pc  = btb.tag_and_target_address[63:32];
  assign w_up_tgt = btb.tag_and_target_address[31:0];
  assign w_up_idx = w_up_pc[INDEX_BITS-1:0];
  assign w_up_tag = w_up_pc[31:INDEX_BITS];
  assign w_up_en  = btb.valid_tag_and_target && !btb.flush_btb;

`ifdef BTB_BYPASS_EN
  assign w_fwd = btb.valid_tag_and_target && btb.lookup_valid &&
                 (btb.lookup_pc == w_up_pc);
`else
  assign w_fwd = 1'b0;
`endif

  always_comb begin
    w_lk_hit    = 1'b0;
    w_lk_way    = '0;
    w_lk_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_lk_hit && r_valid[w_lk_idx][w] && r_tag[w_lk_idx][w] == w_lk_tag) begin
        w_lk_hit    = 1'b1;
        w_lk_way    = WAY_W'(w);
        w_lk_target = r_target[w_lk_idx][w];
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins allocation.
  always_comb begin
    w_up_match     = 1'b0;
    w_up_match_way = '0;
    w_up_free      = 1'b0;
    w_up_free_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_up_idx][w] && r_tag[w_up_idx][w] == w_up_tag) begin
        w_up_match     = 1'b1;
        w_up_match_way = WAY_W'(w);
      end
      if (!r_valid[w_up_idx][w]) begin
        w_up_free     = 1'b1;
        w_up_free_way = WAY_W'(w);
      end
    end
  end

  assign w_victim   = (WAYS == 2) ? r_lru[w_up_idx] : 1'b0;
  assign w_up_way   = w_up_match ? w_up_match_way :
                      (w_up_free ? w_up_free_way : w_victim);
  assign w_up_alloc = !w_up_match && w_up_free;

  always_ff @(posedge clk) begin
    if (reset || btb.flush_btb) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
      end
      r_lru   <= '0;
      r_count <= '0;
    end else begin
      if (btb.valid_tag_and_target) begin
        r_valid[w_up_idx][w_up_way] <= 1'b1;
        if (w_up_alloc) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
      // The update is written after the lookup so it owns LRU on a set collision.
      if (WAYS == 2) begin
        if (btb.lookup_valid && w_lk_hit) begin
          r_lru[w_lk_idx] <= ~w_lk_way;
        end
        if (btb.valid_tag_and_target) begin
          r_lru[w_up_idx] <= ~w_up_way;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_up_en) begin
      r_tag[w_up_idx][w_up_way]    <= w_up_tag;
      r_target[w_up_idx][w_up_way] <= w_up_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_pred      <= '0;
    end else begin
      r_hit_valid <= btb.lookup_valid;
      if (btb.lookup_valid) begin
        if (btb.flush_btb) begin
          r_hit  <= 1'b0;
          r_pred <= '0;
        end else if (w_fwd) begin
          r_hit  <= 1'b1;
          r_pred <= w_up_tgt;
        end else begin
          r_hit  <= w_lk_hit;
          r_pred <= w_lk_hit ? w_lk_target : 32'h0;
        end
      end else begin
        r_hit <= 1'b0;
      end
    end
  end

  assign btb.hit_valid        = r_hit_valid;
  assign btb.hit              = r_hit;
  assign btb.predicted_target = r_pred;
  assign btb.entry_count      = r_count;

endmodule

`default_nettype wire

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Set-associative branch target buffer consumed by the fetch stage; sits directly downstream of the execution stage's BTB update port.
- Records {branch PC, resolved target} pairs that the execution stage sends on valid_tag_and_target / tag_and_target_address.
- Answers fetch-PC lookups one cycle later with hit and predicted target; fetch steers next_PC with that result.

Parameters:
- INDEX_BITS, 3, set index width; set count = 2^INDEX_BITS; tag width = 32 - INDEX_BITS.
- WAYS, 2, associativity; legal values 1 or 2 only; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- lookup_valid  in  1  fetch lookup request this cycle.
- lookup_pc  in  32  fetch PC to look up.
- hit_valid  out  1  registered; high exactly one cycle after lookup_valid was high.
- hit  out  1  registered; lookup matched a valid entry.
- predicted_target  out  32  registered; target of the matching entry, else 0.
- valid_tag_and_target  in  1  update strobe from execution stage; level sampled at posedge, one update per high cycle.
- tag_and_target_address  in  64  [63:32] branch PC, [31:0] target.
- flush_btb  in  1  invalidates all entries.
- entry_count  out  $clog2(WAYS*2^INDEX_BITS)+1  number of valid entries; registered.

Behaviour:
- Address split: index = pc[INDEX_BITS-1:0], tag = pc[31:INDEX_BITS]; default is 3 index bits + 29 tag bits.
- Storage per set/way: valid bit, tag, 32-bit target. Per set, one LRU bit when WAYS=2; it names the way to replace next.
- Reset (sync, highest priority):
  - all valid and LRU bits clear;
  - hit_valid = 0, hit = 0, predicted_target = 0, entry_count = 0;
  - a lookup or update in the reset cycle is dropped.
- Lookup, latency 1:
  - cycle N: lookup_valid = 1;
  - cycle N+1: hit_valid = 1; hit = 1 if any valid way in the set has a matching tag; predicted_target = that target, else 0;
  - if lookup_valid = 0, hit_valid = 0 and hit = 0; predicted_target holds its last value.
- Lookup hit sets the set's LRU to the other way.
- Update at posedge with valid_tag_and_target = 1:
  - if the tag matches a valid way in the set, overwrite that way's target (count unchanged);
  - else allocate the lowest-numbered invalid way (count +1);
  - else replace the LRU way (count unchanged);
  - the written way becomes MRU.
- Same cycle, same set, lookup and update: lookup reads pre-update contents (read-before-write); LRU takes the update's value.
- Duplicate updates of the same PC in consecutive cycles never occupy two ways.
- flush_btb = 1:
  - next cycle all valid bits = 0, LRU = 0, entry_count = 0;
  - an update in the same cycle is dropped;
  - a lookup in the same cycle returns hit_valid = 1, hit = 0, predicted_target = 0.
- entry_count saturates by construction at WAYS*2^INDEX_BITS; never wraps.
- WAYS=1: direct-mapped, no LRU; a miss-update always overwrites.

Optional Feature:
- Macro BTB_BYPASS_EN.
- Defined: when an update and a lookup in the same cycle have equal full PCs, the lookup returns hit = 1 with the update's target (write-forwarding), and LRU marks the written way MRU.
- Undefined: read-before-write as specified above.
- Flush and reset still override in both builds.

Test Plan:
- Reset, then lookup 0x0000_0010 -> next cycle hit_valid = 1, hit = 0, predicted_target = 0, entry_count = 0.
- Update {0x0000_0010, 0x0000_0040}; lookup 0x10 next cycle -> hit = 1, target 0x40, entry_count = 1; repeat the update with target 0x80 -> count stays 1, lookup returns 0x80.
- Updates to 0x08, 0x10, 0x18 (all index 0, WAYS=2); lookup 0x10 between the second and third update -> 0x08 evicted; lookups give 0x08 miss, 0x10 hit, 0x18 hit; count = 2.
- Same-cycle update {0x20, 0x100} and lookup 0x20 on an empty BTB -> hit = 0 without BTB_BYPASS_EN; hit = 1, target 0x100 with it.
- Fill all 16 entries -> entry_count = 16; assert flush_btb together with an update and a lookup -> lookup hit = 0, next cycle entry_count = 0, the dropped update's PC misses afterwards.
- Assert reset in the cycle after lookup_valid -> hit_valid = 0 and hit = 0 at the following edge; all prior entries miss.
